cout_drain_row: RTL and testbench
=================================

// Module: cout_drain_row
// PURPOSE
//  Output-side counterpart of the C-input shift path: unloads one systolic row's accumulators.
//  On acc_done it snapshots all COLS 32-bit results plus the row's compute type.
//  It then streams them out one word per handshake, column 0 first, on a valid/ready port.
//  Sits between the right edge of a PE row (AC cells) and the result writeback.
// PARAMETERS
//  COLS  4   number of accumulator columns in the row (>=1)
//  DW    32  accumulator/result word width
//  IDXW  derived = (COLS>1) ? $clog2(COLS) : 1; width of the column index
// PORTS
//  clk               in   1        rising-edge clock
//  rst               in   1        synchronous reset, active-high
//  acc_done          in   1        one-cycle pulse: row accumulators final this cycle
//  acc_data          in   COLS*DW  column c at [c*DW +: DW]; sampled only with acc_done
//  compute_type_in   in   full_type_t  row compute type; sampled with acc_done
//  cout_valid        out  1        cout_data holds a valid result word
//  cout_ready        in   1        downstream accepts the word this cycle
//  cout_data         out  DW       result word; 0 whenever cout_valid=0
//  cout_idx          out  IDXW     column index of cout_data
//  cout_last         out  1        cout_valid && cout_idx==COLS-1
//  compute_type_out  out  full_type_t  type captured with the current snapshot
//  busy              out  1        high in DRAIN state
//  overrun           out  1        sticky drop flag (only with CDRAIN_OVERRUN_EN)
// BEHAVIOUR
//  - All outputs registered. Reset values:
//    state=IDLE; cout_valid=0; cout_data=0; cout_idx=0; cout_last=0; busy=0; overrun=0.
//    compute_type_out = full_type_t reset value (all-zero encoding).
//  - rst mid-drain: buffered snapshot abandoned, no further words emitted.
//  - FSM IDLE: cout_valid=0.
//    acc_done=1 -> capture acc_data/compute_type_in into snapshot buffer, idx=0, go DRAIN.
//    Latency: acc_done at edge t -> cout_valid=1 with column 0 after edge t+1.
//  - FSM DRAIN: cout_valid=1, cout_data=buf[idx]. Handshake = cout_valid && cout_ready.
//    * handshake, idx<COLS-1 -> idx+1; next column presented the following cycle.
//    * handshake, idx==COLS-1, acc_done=0 -> go IDLE; valid drops next cycle.
//    * handshake, idx==COLS-1, acc_done=1 -> recapture, idx=0, stay DRAIN.
//      Back-to-back rows, no bubble.
//    * no handshake -> cout_data, cout_idx, cout_last, compute_type_out held stable.
//  - acc_done in DRAIN other than on final handshake: new row dropped, snapshot unchanged.
//  - Throughput: COLS cycles per row with cout_ready tied high.
//  - cout_ready is ignored while cout_valid=0. acc_data is ignored while acc_done=0.
//  - COLS=1: each row is a single word with cout_last=1.
// CONFIGURATION
//  `CDRAIN_OVERRUN_EN defined:
//    - overrun port present.
//    - Set on any dropped acc_done (see above); stays set until rst.
//  Not defined:
//    - overrun port absent.
//    - Drops are silent; no other behaviour changes.
// STRUCTURE
//  Shared package params (para_pkg.sv):
//    - full_type_t (existing).
//    - New enum drain_state_t {DRAIN_IDLE, DRAIN_ACTIVE}.
//    - Default constants ROW_COLS=4, ACC_DW=32.
//  Sub-module cdrain_snapshot: COLS x DW capture register with load enable and an idx read mux.
//  Top level holds FSM, index counter, handshake logic and overrun.
// TESTING
//  T1 COLS=4, ready=1, acc_done w/ data {4,3,2,1} (col0=1):
//     cout_data 1,2,3,4 on 4 consecutive cycles; idx 0..3; last only on 4; busy 4 cycles.
//  T2 ready toggles 1,0,0,1,1,0,1 during drain:
//     each word stays stable while ready=0; exactly 4 handshakes; order 1,2,3,4.
//  T3 second acc_done (data {8,7,6,5}) in the same cycle as the idx=3 handshake:
//     stream 1,2,3,4,5,6,7,8 with no valid gap.
//  T4 acc_done at idx=1 during drain:
//     row dropped; words 3,4 unchanged; overrun=1 and held with macro; no overrun port without.
//  T5 rst asserted at idx=2 with ready=0:
//     next cycle valid=0, data=0, idx=0, busy=0; fresh acc_done restarts at column 0.
//  T6 COLS=1, three acc_done pulses 2 cycles apart, ready=1:
//     3 single words, each with last=1 and idx=0.

Source files
------------

// File: rtl/para_pkg.sv
// Shared parameter package for the systolic array datapath.
//
// Contents:
//   full_type_t   - compute type carried alongside a row of results
//                   (all-zero encoding is the reset value)
//   drain_state_t - state encoding for the output drain FSM
//   ROW_COLS      - default number of accumulator columns in a PE row
//   ACC_DW        - default accumulator/result word width
package para_pkg;

   typedef enum logic [2:0] {
      FT_NONE  = 3'd0,
      FT_INT8  = 3'd1,
      FT_INT16 = 3'd2,
      FT_FP16  = 3'd3,
      FT_FP32  = 3'd4
   } full_type_t;

   typedef enum logic {
      DRAIN_IDLE,
      DRAIN_ACTIVE
   } drain_state_t;

   localparam int ROW_COLS = 4;
   localparam int ACC_DW   = 32;

endpackage

// File: rtl/cout_drain_row_snapshot.sv
// cout_drain_row_snapshot (cdrain_snapshot): COLS x DW capture register for one
// row of accumulator results, plus a read mux selected by column index.
//
// Ports:
//   clk     in  rising-edge clock
//   load_i  in  capture data_i into the buffer this cycle
//   data_i  in  COLS*DW packed row, column c at [c*DW +: DW]
//   idx_i   in  column to present on data_o
//   data_o  out buffered word for column idx_i
//
// The buffer needs no reset: the drain FSM masks its contents until a
// capture has happened.
module cout_drain_row_snapshot
   import para_pkg::*;
#(
   parameter int COLS = ROW_COLS,
   parameter int DW   = ACC_DW,
   parameter int IDXW = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                 clk,
   input  logic                 load_i,
   input  logic [COLS*DW-1:0]   data_i,
   input  logic [IDXW-1:0]      idx_i,
   output logic [DW-1:0]        data_o
);

   logic [DW-1:0] bufQ [COLS];

   // Capture the whole row at once when the FSM asks for it.
   always_ff @(posedge clk) begin
      if (load_i) begin
         for (int c = 0; c < COLS; c++) begin
            bufQ[c] <= data_i[c*DW +: DW];
         end
      end
   end

   // Compare-based mux keeps the index width independent of the array size
   // (matters for COLS=1 and non-power-of-two COLS).
   always_comb begin
      data_o = '0;
      for (int c = 0; c < COLS; c++) begin
         if (idx_i == IDXW'(c)) begin
            data_o = bufQ[c];
         end
      end
   end

endmodule

// File: rtl/cout_drain_row.sv
// cout_drain_row: unloads one systolic row's accumulators. On acc_done the
// COLS results and the row compute type are snapshotted, then streamed out one
// word per valid/ready handshake, column 0 first.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   acc_done          one-cycle pulse, row accumulators final this cycle
//   acc_data          COLS*DW packed results, column c at [c*DW +: DW]
//   compute_type_in   row compute type, sampled with acc_done
//   cout_valid        cout_data holds a valid word
//   cout_ready        downstream accepts the word this cycle
//   cout_data         result word, 0 while cout_valid=0
//   cout_idx          column index of cout_data
//   cout_last         valid word is the final column of the row
//   compute_type_out  type captured with the current snapshot
//   busy              high while draining
//   overrun           sticky flag for a dropped acc_done
//                     (present only when CDRAIN_OVERRUN_EN is defined)
//
// Configuration macro: CDRAIN_OVERRUN_EN
module cout_drain_row
   import para_pkg::*;
#(
   parameter int COLS = ROW_COLS,
   parameter int DW   = ACC_DW,
   parameter int IDXW = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 acc_done,
   input  logic [COLS*DW-1:0]   acc_data,
   input  full_type_t           compute_type_in,
   output logic                 cout_valid,
   input  logic                 cout_ready,
   output logic [DW-1:0]        cout_data,
   output logic [IDXW-1:0]      cout_idx,
   output logic                 cout_last,
   output full_type_t           compute_type_out,
   output logic                 busy
`ifdef CDRAIN_OVERRUN_EN
   ,output logic                overrun
`endif
);

   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(COLS - 1);

   drain_state_t     stateQ, stateD;
   logic [IDXW-1:0]  idxQ, idxD;
   full_type_t       typeQ;
   logic             load;
   logic             handshake;
   logic             atLast;
   logic [DW-1:0]    snapWord;

   assign handshake = (stateQ == DRAIN_ACTIVE) && cout_ready;
   assign atLast    = (idxQ == LAST_IDX);

   // Next-state logic. A new row is only taken when idle or in the same cycle
   // as the final word's handshake, which gives back-to-back rows without a
   // bubble. The index returns to 0 whenever the FSM goes idle.
   always_comb begin
      stateD = stateQ;
      idxD   = idxQ;
      load   = 1'b0;
      case (stateQ)
         DRAIN_IDLE: begin
            if (acc_done) begin
               load   = 1'b1;
               idxD   = '0;
               stateD = DRAIN_ACTIVE;
            end
         end
         DRAIN_ACTIVE: begin
            if (handshake) begin
               if (!atLast) begin
                  idxD = idxQ + IDXW'(1);
               end else if (acc_done) begin
                  load = 1'b1;
                  idxD = '0;
               end else begin
                  idxD   = '0;
                  stateD = DRAIN_IDLE;
               end
            end
         end
         default: begin
            stateD = DRAIN_IDLE;
            idxD   = '0;
         end
      endcase
   end

   // State, index and captured type registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateQ <= DRAIN_IDLE;
         idxQ   <= '0;
         typeQ  <= FT_NONE;
      end else begin
         stateQ <= stateD;
         idxQ   <= idxD;
         if (load) begin
            typeQ <= compute_type_in;
         end
      end
   end

   cout_drain_row_snapshot #(
      .COLS (COLS),
      .DW   (DW),
      .IDXW (IDXW)
   ) uSnapshot (
      .clk    (clk),
      .load_i (load),
      .data_i (acc_data),
      .idx_i  (idxQ),
      .data_o (snapWord)
   );

   // Outputs are decoded purely from registers, so nothing combinational
   // from the inputs reaches the output port.
   assign cout_valid       = (stateQ == DRAIN_ACTIVE);
   assign busy             = (stateQ == DRAIN_ACTIVE);
   assign cout_data        = cout_valid ? snapWord : '0;
   assign cout_idx         = idxQ;
   assign cout_last        = cout_valid && atLast;
   assign compute_type_out = typeQ;

`ifdef CDRAIN_OVERRUN_EN
   logic overrunQ;
   logic drop;

   // Any acc_done that is not consumed by the idle or final-handshake
   // capture paths is a dropped row.
   assign drop = (stateQ == DRAIN_ACTIVE) && acc_done && !(handshake && atLast);

   // Sticky until reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overrunQ <= 1'b0;
      end else if (drop) begin
         overrunQ <= 1'b1;
      end
   end

   assign overrun = overrunQ;
`endif

endmodule

// File: tb/tb_cout_drain_row.sv
// Testbench for cout_drain_row. A reference model counts outstanding words and
// decides row acceptance from the handshake rules; accepted rows are pushed
// into an expected-word queue that a negedge monitor pops on each handshake.
// A second instance with COLS=1 covers the single-word row case.
module tb_cout_drain_row;
   import para_pkg::*;

   localparam int COLS = 4;
   localparam int DW   = 32;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  idx;
      logic        last;
      full_type_t  ft;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                accDone = 1'b0;
   logic [COLS*DW-1:0]  accData = '0;
   full_type_t          typeIn = FT_NONE;
   logic                coutValid;
   logic                coutReady = 1'b0;
   logic [DW-1:0]       coutData;
   logic [1:0]          coutIdx;
   logic                coutLast;
   full_type_t          typeOut;
   logic                busy;

   logic                accDone1 = 1'b0;
   logic [DW-1:0]       accData1 = '0;
   full_type_t          typeIn1 = FT_NONE;
   logic                valid1;
   logic [DW-1:0]       data1;
   logic [0:0]          idx1;
   logic                last1;
   full_type_t          typeOut1;
   logic                busy1;

`ifdef CDRAIN_OVERRUN_EN
   logic                overrun;
   logic                overrun1;
`endif

   int   checks = 0;
   int   failures = 0;
   int   pending = 0;
   bit   expOverrun = 1'b0;
   bit   monEn = 1'b0;
   exp_t expQ[$];

   always #5 clk = ~clk;

   cout_drain_row #(.COLS(COLS), .DW(DW)) dut (
      .clk              (clk),
      .rst              (rst),
      .acc_done         (accDone),
      .acc_data         (accData),
      .compute_type_in  (typeIn),
      .cout_valid       (coutValid),
      .cout_ready       (coutReady),
      .cout_data        (coutData),
      .cout_idx         (coutIdx),
      .cout_last        (coutLast),
      .compute_type_out (typeOut),
      .busy             (busy)
`ifdef CDRAIN_OVERRUN_EN
      ,.overrun         (overrun)
`endif
   );

   cout_drain_row #(.COLS(1), .DW(DW)) dut1 (
      .clk              (clk),
      .rst              (rst),
      .acc_done         (accDone1),
      .acc_data         (accData1),
      .compute_type_in  (typeIn1),
      .cout_valid       (valid1),
      .cout_ready       (1'b1),
      .cout_data        (data1),
      .cout_idx         (idx1),
      .cout_last        (last1),
      .compute_type_out (typeOut1),
      .busy             (busy1)
`ifdef CDRAIN_OVERRUN_EN
      ,.overrun         (overrun1)
`endif
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [COLS*DW-1:0] mkRow(input logic [31:0] w0, w1, w2, w3);
      return {w3, w2, w1, w0};
   endfunction

   // One clock of stimulus. The model decides from its own word count whether
   // a handshake happens and whether a pulsed row is accepted or dropped.
   task automatic applyStimulus(input logic rdy, input logic done,
                                input logic [COLS*DW-1:0] data, input full_type_t ft);
      bit hs;
      bit accept;
      hs     = (pending > 0) && rdy;
      accept = done && ((pending == 0) || (pending == 1 && hs));
      coutReady = rdy;
      accDone   = done;
      accData   = data;
      typeIn    = ft;
      @(posedge clk);
      #1;
      pending = pending - (hs ? 1 : 0) + (accept ? COLS : 0);
      if (done && !accept) expOverrun = 1'b1;
      if (accept) begin
         for (int c = 0; c < COLS; c++) begin
            exp_t e;
            e.data = data[c*DW +: DW];
            e.idx  = 2'(c);
            e.last = (c == COLS - 1);
            e.ft   = ft;
            expQ.push_back(e);
         end
      end
   endtask

   task automatic idleSteps(input logic rdy, input int n);
      for (int i = 0; i < n; i++) applyStimulus(rdy, 1'b0, '0, FT_NONE);
   endtask

   task automatic resetDut();
      monEn     = 1'b0;
      rst       = 1'b1;
      accDone   = 1'b0;
      coutReady = 1'b0;
      accDone1  = 1'b0;
      @(posedge clk);
      #1;
      pending    = 0;
      expOverrun = 1'b0;
      expQ.delete();
      rst = 1'b0;
      checkOutput("rstValid", 32'(coutValid), 0);
      checkOutput("rstData", coutData, 0);
      checkOutput("rstIdx", 32'(coutIdx), 0);
      checkOutput("rstLast", 32'(coutLast), 0);
      checkOutput("rstBusy", 32'(busy), 0);
      checkOutput("rstType", 32'(typeOut), 32'(FT_NONE));
`ifdef CDRAIN_OVERRUN_EN
      checkOutput("rstOverrun", 32'(overrun), 0);
`endif
      monEn = 1'b1;
   endtask

   // Monitor: compares presented words against the expected queue on every
   // handshake, and valid/busy against the model's outstanding-word count.
   always @(negedge clk) begin
      if (monEn) begin
         checkOutput("valid", 32'(coutValid), 32'(pending > 0));
         checkOutput("busy", 32'(busy), 32'(pending > 0));
         if (!coutValid) begin
            checkOutput("idleData", coutData, 0);
            checkOutput("idleLast", 32'(coutLast), 0);
         end
         if (coutValid && coutReady) begin
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpectedWord: got %0h expected none at %0t", coutData, $time);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               checkOutput("data", coutData, e.data);
               checkOutput("idx", 32'(coutIdx), 32'(e.idx));
               checkOutput("last", 32'(coutLast), 32'(e.last));
               checkOutput("type", 32'(typeOut), 32'(e.ft));
            end
         end
`ifdef CDRAIN_OVERRUN_EN
         checkOutput("overrun", 32'(overrun), 32'(expOverrun));
`endif
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] v1 [3];
      full_type_t  t1 [3];
      logic        rseq [7];

      resetDut();

      // T1: full row with ready high.
      applyStimulus(1'b1, 1'b1, mkRow(1, 2, 3, 4), FT_INT8);
      idleSteps(1'b1, 5);

      // T2: ready toggling during the drain.
      rseq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      applyStimulus(1'b0, 1'b1, mkRow(1, 2, 3, 4), FT_FP16);
      foreach (rseq[i]) applyStimulus(rseq[i], 1'b0, '0, FT_NONE);
      idleSteps(1'b1, 3);

      // T3: second row captured on the final handshake, no gap.
      applyStimulus(1'b1, 1'b1, mkRow(1, 2, 3, 4), FT_INT16);
      idleSteps(1'b1, 3);
      applyStimulus(1'b1, 1'b1, mkRow(5, 6, 7, 8), FT_FP32);
      idleSteps(1'b1, 6);

      // T4: row arriving mid-drain is dropped.
      applyStimulus(1'b1, 1'b1, mkRow(1, 2, 3, 4), FT_INT8);
      applyStimulus(1'b1, 1'b0, '0, FT_NONE);
      applyStimulus(1'b1, 1'b1, mkRow(9, 10, 11, 12), FT_FP32);
      idleSteps(1'b1, 6);

      // T5: reset during a stalled drain, then restart.
      applyStimulus(1'b1, 1'b1, mkRow(21, 22, 23, 24), FT_FP16);
      idleSteps(1'b1, 2);
      idleSteps(1'b0, 1);
      resetDut();
      applyStimulus(1'b1, 1'b1, mkRow(31, 32, 33, 34), FT_INT16);
      idleSteps(1'b1, 6);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                       mkRow($urandom, $urandom, $urandom, $urandom),
                       full_type_t'($urandom_range(0, 4)));
      end
      idleSteps(1'b1, 12);
      checkOutput("queueEmpty", 32'(expQ.size()), 0);

      // T6: COLS=1 instance, three pulses two cycles apart.
      for (int k = 0; k < 3; k++) begin
         v1[k] = $urandom;
         t1[k] = full_type_t'($urandom_range(1, 4));
      end
      for (int k = 0; k < 6; k++) begin
         accDone1 = (k % 2 == 0);
         accData1 = v1[k / 2];
         typeIn1  = t1[k / 2];
         @(posedge clk);
         #1;
         if (k % 2 == 0) begin
            checkOutput("c1Valid", 32'(valid1), 1);
            checkOutput("c1Data", data1, v1[k / 2]);
            checkOutput("c1Idx", 32'(idx1), 0);
            checkOutput("c1Last", 32'(last1), 1);
            checkOutput("c1Type", 32'(typeOut1), 32'(t1[k / 2]));
         end else begin
            checkOutput("c1Valid", 32'(valid1), 0);
            checkOutput("c1Data", data1, 0);
            checkOutput("c1Last", 32'(last1), 0);
         end
      end
      accDone1 = 1'b0;
`ifdef CDRAIN_OVERRUN_EN
      checkOutput("c1Overrun", 32'(overrun1), 0);
`endif

      monEn = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
